// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU MEM stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if;
  logic        i_memRd;
  logic        i_memWr;
  logic [15:0] i_addr;
  logic [15:0] i_wrData;
  logic [15:0] o_rdData;
  logic        o_rdValid;
  logic        o_stall;

  modport master (
    output i_memRd, i_memWr, i_addr, i_wrData,
    input  o_rdData, o_rdValid, o_stall
  );

  modport slave (
    input  i_memRd, i_memWr, i_addr, i_wrData,
    output o_rdData, o_rdValid, o_stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: single-port word array with fixed
// access latency, a one-entry posted write buffer and buffer-hit read forwarding.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_FULL    = 4'(LATENCY - 1);
  // An idle read uses its request cycle as the first access cycle, so it waits one less.
  localparam logic [3:0] CNT_IDLE_RD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic [DEPTH_LOG2-1:0] buf_addr_r;
  logic [15:0]           buf_data_r;
  logic [15:0]           rd_data_r;
  logic [15:0]           mem_r [DEPTH];

  logic [DEPTH_LOG2-1:0] addr_idx_s;
  logic                  rd_req_s;
  logic                  hit_s;
  logic                  wr_accept_s;
  logic                  mem_we_s;
  logic                  stall_s;
  logic                  rd_valid_s;
  logic [15:0]           rd_data_s;
  logic                  unused_addr_s;

  assign addr_idx_s    = bus.i_addr[DEPTH_LOG2-1:0];
  assign unused_addr_s = ^bus.i_addr;

  // Request decode, forwarding and stall generation.
  always_comb begin
    rd_req_s    = bus.i_memRd & ~bus.i_memWr;
    hit_s       = rd_req_s & (state_r == DRAIN) & (addr_idx_s == buf_addr_r);
    wr_accept_s = bus.i_memWr & ((state_r == IDLE) | (state_r == RD_DONE));
    mem_we_s    = (state_r == DRAIN) & (cnt_r == 4'd0) & ~rst;
    stall_s     = 1'b0;
    rd_valid_s  = 1'b0;
    rd_data_s   = rd_data_r;
    if (rst) begin
      stall_s    = 1'b0;
      rd_valid_s = 1'b0;
    end else if (bus.i_memWr) begin
      stall_s = ~wr_accept_s;
    end else if (rd_req_s) begin
      if (hit_s) begin
        rd_valid_s = 1'b1;
        rd_data_s  = buf_data_r;
      end else if (state_r == RD_DONE) begin
        rd_valid_s = 1'b1;
      end else begin
        stall_s = 1'b1;
      end
    end else begin
      stall_s    = 1'b0;
      rd_valid_s = 1'b0;
    end
  end

  // Control FSM, latency counter, write buffer and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      buf_addr_r <= {DEPTH_LOG2{1'b0}};
      buf_data_r <= 16'h0000;
      rd_data_r  <= 16'h0000;
    end else begin
      if (hit_s) begin
        rd_data_r <= buf_data_r;
      end
      if (wr_accept_s) begin
        buf_addr_r <= addr_idx_s;
        buf_data_r <= bus.i_wrData;
      end
      case (state_r)
        IDLE: begin
          if (wr_accept_s) begin
            state_r <= DRAIN;
            cnt_r   <= CNT_FULL;
          end else if (rd_req_s) begin
            if (LATENCY == 1) begin
              state_r   <= RD_DONE;
              rd_data_r <= mem_r[addr_idx_s];
            end else begin
              state_r <= RD_WAIT;
              cnt_r   <= CNT_IDLE_RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          if (cnt_r == 4'd0) begin
            // A pending miss gets the full array latency once the drain frees the port.
            if (rd_req_s & ~hit_s) begin
              state_r <= RD_WAIT;
              cnt_r   <= CNT_FULL;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RD_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r   <= RD_DONE;
            rd_data_r <= mem_r[addr_idx_s];
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RD_DONE: begin
          if (wr_accept_s) begin
            state_r <= DRAIN;
            cnt_r   <= CNT_FULL;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Array write at the end of the last drain cycle; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[buf_addr_r] <= buf_data_r;
    end
  end

  assign bus.o_stall   = stall_s;
  assign bus.o_rdValid = rd_valid_s;
  assign bus.o_rdData  = rd_data_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with LATENCY = 4.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] data);
    @(posedge clk);
    #1;
    rst          = r;
    bus.i_memRd  = rd;
    bus.i_memWr  = wr;
    bus.i_addr   = addr;
    bus.i_wrData = data;
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic write_word(input logic [15:0] addr, input logic [15:0] data);
    int n;
    n = 0;
    drive(1'b0, 1'b0, 1'b1, addr, data);
    while (bus.o_stall === 1'b1 && n < 40) begin
      n++;
      drive(1'b0, 1'b0, 1'b1, addr, data);
    end
    nop(1);
  endtask

  task automatic read_word(input logic [15:0] addr, output logic [15:0] data,
                           output logic valid, output int stalls);
    stalls = 0;
    drive(1'b0, 1'b1, 1'b0, addr, 16'h0000);
    while (bus.o_stall === 1'b1 && stalls < 40) begin
      stalls++;
      drive(1'b0, 1'b1, 1'b0, addr, 16'h0000);
    end
    valid = bus.o_rdValid;
    data  = bus.o_rdData;
    nop(1);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", bus.o_stall);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++;
    if (bus.o_rdData !== 16'h0000 || bus.o_rdValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h valid=%b want 0000/0", bus.o_rdData, bus.o_rdValid);
    end
    nop(1);
    checks++;
    if (bus.o_stall !== 1'b0 || bus.o_rdValid !== 1'b0 || bus.o_rdData !== 16'h0000) begin
      errors++;
      $display("FAIL reset_idle: got stall=%b valid=%b data=%h want 0/0/0000",
               bus.o_stall, bus.o_rdValid, bus.o_rdData);
    end
    write_word(16'h0041, 16'h5A5A);
    nop(5);
    write_word(16'h0060, 16'h0606);
    nop(5);
  endtask

  task automatic test_basic;
    logic [15:0] d;
    logic        v;
    int          s;
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234);
    checks++;
    if (bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL basic_wr_stall: got %b want 0", bus.o_stall);
    end
    nop(5);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      checks++;
      if (bus.o_stall !== 1'b1 || bus.o_rdValid !== 1'b0) begin
        errors++;
        $display("FAIL basic_rd_wait c%0d: got stall=%b valid=%b want 1/0", c, bus.o_stall, bus.o_rdValid);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (bus.o_stall !== 1'b0 || bus.o_rdValid !== 1'b1 || bus.o_rdData !== 16'h1234) begin
      errors++;
      $display("FAIL basic_rd_done: got stall=%b valid=%b data=%h want 0/1/1234",
               bus.o_stall, bus.o_rdValid, bus.o_rdData);
    end
    nop(1);
    checks++;
    if (bus.o_stall !== 1'b0 || bus.o_rdValid !== 1'b0 || bus.o_rdData !== 16'h1234) begin
      errors++;
      $display("FAIL basic_hold: got stall=%b valid=%b data=%h want 0/0/1234",
               bus.o_stall, bus.o_rdValid, bus.o_rdData);
    end
    read_word(16'h0410, d, v, s);
    checks++;
    if (d !== 16'h1234 || v !== 1'b1 || s != 4) begin
      errors++;
      $display("FAIL basic_alias: got data=%h valid=%b stalls=%0d want 1234/1/4", d, v, s);
    end
  endtask

  task automatic test_hit;
    logic [15:0] d;
    logic        v;
    int          s;
    drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'hBEEF);
    checks++;
    if (bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL hit_wr_stall: got %b want 0", bus.o_stall);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    checks++;
    if (bus.o_stall !== 1'b0 || bus.o_rdValid !== 1'b1 || bus.o_rdData !== 16'hBEEF) begin
      errors++;
      $display("FAIL hit_forward: got stall=%b valid=%b data=%h want 0/1/beef",
               bus.o_stall, bus.o_rdValid, bus.o_rdData);
    end
    nop(1);
    checks++;
    if (bus.o_rdValid !== 1'b0 || bus.o_rdData !== 16'hBEEF) begin
      errors++;
      $display("FAIL hit_hold: got valid=%b data=%h want 0/beef", bus.o_rdValid, bus.o_rdData);
    end
    nop(4);
    read_word(16'h0020, d, v, s);
    checks++;
    if (d !== 16'hBEEF || v !== 1'b1 || s != 4) begin
      errors++;
      $display("FAIL hit_array: got data=%h valid=%b stalls=%0d want beef/1/4", d, v, s);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    logic        v;
    int          s;
    drive(1'b0, 1'b0, 1'b1, 16'h0030, 16'h1111);
    checks++;
    if (bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got stall=%b want 0", bus.o_stall);
    end
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 1'b1, 16'h0031, 16'h2222);
      checks++;
      if (bus.o_stall !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall c%0d: got stall=%b want 1", c, bus.o_stall);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 16'h0031, 16'h2222);
    checks++;
    if (bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got stall=%b want 0 in cycle 5", bus.o_stall);
    end
    nop(5);
    read_word(16'h0030, d, v, s);
    checks++;
    if (d !== 16'h1111 || v !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read0: got data=%h valid=%b want 1111/1", d, v);
    end
    read_word(16'h0031, d, v, s);
    checks++;
    if (d !== 16'h2222 || v !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read1: got data=%h valid=%b want 2222/1", d, v);
    end
  endtask

  task automatic test_miss_drain;
    logic [15:0] d;
    logic        v;
    int          s;
    drive(1'b0, 1'b0, 1'b1, 16'h0040, 16'hC3C3);
    checks++;
    if (bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL miss_wr_stall: got %b want 0", bus.o_stall);
    end
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0000);
      checks++;
      if (bus.o_stall !== 1'b1 || bus.o_rdValid !== 1'b0) begin
        errors++;
        $display("FAIL miss_wait c%0d: got stall=%b valid=%b want 1/0", c, bus.o_stall, bus.o_rdValid);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0000);
    checks++;
    if (bus.o_stall !== 1'b0 || bus.o_rdValid !== 1'b1 || bus.o_rdData !== 16'h5A5A) begin
      errors++;
      $display("FAIL miss_done: got stall=%b valid=%b data=%h want 0/1/5a5a in cycle 9",
               bus.o_stall, bus.o_rdValid, bus.o_rdData);
    end
    nop(1);
    read_word(16'h0040, d, v, s);
    checks++;
    if (d !== 16'hC3C3 || v !== 1'b1 || s != 4) begin
      errors++;
      $display("FAIL miss_drained: got data=%h valid=%b stalls=%0d want c3c3/1/4", d, v, s);
    end
  endtask

  task automatic test_simultaneous;
    logic [15:0] d;
    logic        v;
    int          s;
    drive(1'b0, 1'b1, 1'b1, 16'h0050, 16'h7777);
    checks++;
    if (bus.o_stall !== 1'b0 || bus.o_rdValid !== 1'b0 || bus.o_rdData !== 16'hC3C3) begin
      errors++;
      $display("FAIL simul_accept: got stall=%b valid=%b data=%h want 0/0/c3c3",
               bus.o_stall, bus.o_rdValid, bus.o_rdData);
    end
    nop(4);
    read_word(16'h0050, d, v, s);
    checks++;
    if (d !== 16'h7777 || v !== 1'b1 || s != 4) begin
      errors++;
      $display("FAIL simul_read: got data=%h valid=%b stalls=%0d want 7777/1/4", d, v, s);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    logic        v;
    int          s;
    logic        seen;
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (bus.o_stall !== 1'b0 || bus.o_rdValid !== 1'b0) begin
      errors++;
      $display("FAIL rstrd_during: got stall=%b valid=%b want 0/0", bus.o_stall, bus.o_rdValid);
    end
    nop(1);
    checks++;
    if (bus.o_rdData !== 16'h0000 || bus.o_rdValid !== 1'b0 || bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstrd_after: got data=%h valid=%b stall=%b want 0000/0/0",
               bus.o_rdData, bus.o_rdValid, bus.o_stall);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nop(1);
      if (bus.o_rdValid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstrd_aborted: got late valid=%b want 0", seen);
    end
    read_word(16'h0031, d, v, s);
    checks++;
    if (d !== 16'h2222 || v !== 1'b1) begin
      errors++;
      $display("FAIL rstwr_pre: got data=%h valid=%b want 2222/1", d, v);
    end
    drive(1'b0, 1'b0, 1'b1, 16'h0060, 16'h9999);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    nop(1);
    checks++;
    if (bus.o_rdData !== 16'h0000 || bus.o_rdValid !== 1'b0 || bus.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstwr_after: got data=%h valid=%b stall=%b want 0000/0/0",
               bus.o_rdData, bus.o_rdValid, bus.o_stall);
    end
    nop(5);
    read_word(16'h0060, d, v, s);
    checks++;
    if (d !== 16'h0606 || v !== 1'b1 || s != 4) begin
      errors++;
      $display("FAIL rstwr_discard: got data=%h valid=%b stalls=%0d want 0606/1/4", d, v, s);
    end
  endtask

  initial begin
    bus.i_memRd  = 1'b0;
    bus.i_memWr  = 1'b0;
    bus.i_addr   = 16'h0000;
    bus.i_wrData = 16'h0000;
    test_reset();
    test_basic();
    test_hit();
    test_back_to_back();
    test_miss_drain();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
